// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Latency: none (types and pure functions only).
// Backpressure: none.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } scan_state_t;

    // Index of the lowest-numbered low row bit (0 when no bit is low).
    function automatic logic [1:0] low_row(input logic [NUM_ROWS-1:0] pat);
        low_row = 2'd0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!pat[r]) begin
                low_row = r[1:0];
            end
        end
    endfunction

    // True when more than one row line is pulled low.
    function automatic logic multi_low(input logic [NUM_ROWS-1:0] pat);
        return ($countones(~pat) > 1);
    endfunction

    // Active-low column drive with only column c pulled low.
    function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-report bundle between the scanner and its neighbours.
// Latency: none (wiring only).
// Backpressure: none; key_valid is a one-cycle strobe with no ready.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [NUM_ROWS-1:0] rows;
    logic [NUM_COLS-1:0] cols;
    logic                key_valid;
    key_code_t           key_code;
    logic                key_held;

    // Scanner side: reads the pins, drives columns and key reports.
    modport master (
        input  rows,
        output cols,
        output key_valid,
        output key_code,
        output key_held
    );

    // Keypad / consumer side.
    modport slave (
        output rows,
        input  cols,
        input  key_valid,
        input  key_code,
        input  key_held
    );

endinterface

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
// Latency: 2 cycles from rows to srows.
// Backpressure: none.
module keypad_scanner_sync (
    input  logic       clk,
    input  logic [3:0] rows,
    output logic [3:0] srows
);

    logic [3:0] meta;

    // Two back-to-back capture stages to resolve metastability.
    always_ff @(posedge clk) begin
        meta  <= rows;
        srows <= meta;
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column rotation, press/release debounce, one strobe per key.
// Latency: 2-cycle row sync, SCAN_CYCLES dwell, DEBOUNCE_CYCLES to strobe; outputs registered.
// Backpressure: none. Optional build macro KEYSCAN_MULTIKEY_REJECT_EN rejects multi-row patterns.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.master  bus
);

    localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_ROWS-1:0] srows;
    logic [NUM_ROWS-1:0] pattern;
    scan_state_t         state;
    logic [CNT_W-1:0]    cnt;
    logic [1:0]          col;
    logic [NUM_COLS-1:0] cols_q;
    logic                key_valid_q;
    key_code_t           key_code_q;
    logic                key_held_q;
    logic                press_now;
    logic                deb_match;
    logic                all_high;

    keypad_scanner_sync u_sync (
        .clk   (clk),
        .rows  (bus.rows),
        .srows (srows)
    );

    // Press qualification of the synchronized rows, with optional multi-key rejection.
    always_comb begin
        all_high = (srows == 4'hF);
`ifdef KEYSCAN_MULTIKEY_REJECT_EN
        press_now = !all_high && !multi_low(srows);
        deb_match = (srows == pattern) && !multi_low(srows);
`else
        press_now = !all_high;
        deb_match = (srows == pattern);
`endif
    end

    // Scan/debounce state machine; every output is a register written here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SCAN;
            cnt         <= '0;
            col         <= 2'd0;
            cols_q      <= 4'b1110;
            pattern     <= 4'hF;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            case (state)
                SCAN: begin
                    if (cnt == SCAN_LAST) begin
                        cnt <= '0;
                        if (press_now) begin
                            pattern <= srows;
                            state   <= DEBOUNCE;
                        end else begin
                            col    <= col + 2'd1;
                            cols_q <= col_drive(col + 2'd1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (!deb_match) begin
                        // Bounce or early release: drop the candidate and move on.
                        state  <= SCAN;
                        cnt    <= '0;
                        col    <= col + 2'd1;
                        cols_q <= col_drive(col + 2'd1);
                    end else if (cnt == DEB_LAST) begin
                        state       <= HELD;
                        cnt         <= '0;
                        key_valid_q <= 1'b1;
                        key_code_q  <= {low_row(pattern), col};
                        key_held_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    cnt <= '0;
                    if (all_high) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!all_high) begin
                        // Contact re-closed: the key is still held.
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state      <= SCAN;
                        cnt        <= '0;
                        key_held_q <= 1'b0;
                        col        <= col + 2'd1;
                        cols_q     <= col_drive(col + 2'd1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= SCAN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.cols      = cols_q;
    assign bus.key_valid = key_valid_q;
    assign bus.key_code  = key_code_q;
    assign bus.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational keypad model.
// Cycle 0 is the interval right after the last reset edge; outputs sampled 1 time unit after each edge.
// Expected cycles are hand-derived for SCAN_CYCLES=4, DEBOUNCE_CYCLES=16.
module tb_keypad_scanner;
    import keypad_pkg::*;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pressed = '0;

    keypad_scanner_if bus ();

    keypad_scanner #(
        .SCAN_CYCLES     (4),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        bus.rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4 + c] && !bus.cols[c]) begin
                    bus.rows[r] = 1'b0;
                end
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int strobes = 0;
    int first_strobe = -1;

    typedef struct {
        int        row;
        int        col;
        logic [3:0] code;
        logic [3:0] cols;
        int        strobe_cyc;
    } press_vec_t;

    press_vec_t  tbl [5];
    logic [3:0]  idle_cols [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.key_valid === 1'b1) begin
            strobes++;
            if (first_strobe < 0) first_strobe = cyc;
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        pressed = '0;
        repeat (3) tick();
        reset        = 1'b0;
        cyc          = 0;
        strobes      = 0;
        first_strobe = -1;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        int exp_strobes;
        int exp_first;
        logic [3:0] exp_cols4;

        tbl[0] = '{row: 0, col: 0, code: 4'h0, cols: 4'b1110, strobe_cyc: 20};
        tbl[1] = '{row: 2, col: 1, code: 4'h9, cols: 4'b1101, strobe_cyc: 24};
        tbl[2] = '{row: 1, col: 2, code: 4'h6, cols: 4'b1011, strobe_cyc: 28};
        tbl[3] = '{row: 3, col: 3, code: 4'hF, cols: 4'b0111, strobe_cyc: 32};
        tbl[4] = '{row: 3, col: 0, code: 4'hC, cols: 4'b1110, strobe_cyc: 20};
        idle_cols[0] = 4'b1110;
        idle_cols[1] = 4'b1101;
        idle_cols[2] = 4'b1011;
        idle_cols[3] = 4'b0111;

        // Reset values after one edge with reset high.
        #1;
        tick();
        check("reset_cols", 32'(bus.cols), 32'h0000000E);
        check("reset_valid", 32'(bus.key_valid), 32'h0);
        check("reset_code", 32'(bus.key_code), 32'h0);
        check("reset_held", 32'(bus.key_held), 32'h0);

        // Idle rotation: each column held for 4 cycles.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            check("idle_cols", 32'(bus.cols), 32'(idle_cols[(k / 4) % 4]));
            tick();
        end
        check("idle_no_strobe", 32'(strobes), 32'h0);

        // Single-key presses across the matrix.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            pressed[tbl[i].row*4 + tbl[i].col] = 1'b1;
            run_to(60);
            check("tbl_strobes", 32'(strobes), 32'd1);
            check("tbl_strobe_cyc", 32'(first_strobe), 32'(tbl[i].strobe_cyc));
            check("tbl_code", 32'(bus.key_code), 32'(tbl[i].code));
            check("tbl_cols", 32'(bus.cols), 32'(tbl[i].cols));
            check("tbl_held", 32'(bus.key_held), 32'h1);
        end

        // Clean press of (2,1) held long, then released.
        do_reset();
        pressed[9] = 1'b1;
        run_to(124);
        check("long_strobes", 32'(strobes), 32'd1);
        check("long_first", 32'(first_strobe), 32'd24);
        check("long_code", 32'(bus.key_code), 32'h9);
        check("long_cols", 32'(bus.cols), 32'hD);
        check("long_held", 32'(bus.key_held), 32'h1);
        pressed = '0;
        run_to(142);
        check("rel_held_still", 32'(bus.key_held), 32'h1);
        check("rel_cols_frozen", 32'(bus.cols), 32'hD);
        tick();
        check("rel_held_drop", 32'(bus.key_held), 32'h0);
        check("rel_cols_adv", 32'(bus.cols), 32'hB);
        check("rel_strobes", 32'(strobes), 32'd1);

        // Press bounce: open one cycle so the debouncer sees a mismatch at count 5.
        do_reset();
        pressed[9] = 1'b1;
        run_to(11);
        pressed = '0;
        tick();
        pressed[9] = 1'b1;
        tick();
        check("pb_cols_13", 32'(bus.cols), 32'hD);
        tick();
        check("pb_cols_14", 32'(bus.cols), 32'hB);
        pressed = '0;
        run_to(40);
        check("pb_strobes", 32'(strobes), 32'd0);
        check("pb_held", 32'(bus.key_held), 32'h0);

        // Release bounce: key re-closes for 3 cycles during the release window.
        do_reset();
        pressed[9] = 1'b1;
        run_to(40);
        check("rb_first", 32'(first_strobe), 32'd24);
        pressed = '0;
        run_to(48);
        pressed[9] = 1'b1;
        run_to(51);
        pressed = '0;
        run_to(52);
        check("rb_held_52", 32'(bus.key_held), 32'h1);
        run_to(69);
        check("rb_held_69", 32'(bus.key_held), 32'h1);
        check("rb_cols_69", 32'(bus.cols), 32'hD);
        tick();
        check("rb_held_70", 32'(bus.key_held), 32'h0);
        check("rb_cols_70", 32'(bus.cols), 32'hB);
        check("rb_strobes", 32'(strobes), 32'd1);

        // Rows 1 and 3 both pressed on column 0.
`ifdef KEYSCAN_MULTIKEY_REJECT_EN
        exp_strobes = 0;
        exp_first   = -1;
        exp_cols4   = 4'b1101;
`else
        exp_strobes = 1;
        exp_first   = 20;
        exp_cols4   = 4'b1110;
`endif
        do_reset();
        pressed[4]  = 1'b1;
        pressed[12] = 1'b1;
        run_to(4);
        check("mk_cols_4", 32'(bus.cols), 32'(exp_cols4));
        run_to(40);
        check("mk_strobes", 32'(strobes), 32'(exp_strobes));
        check("mk_first", 32'(first_strobe), 32'(exp_first));
        if (exp_strobes == 1) begin
            check("mk_code", 32'(bus.key_code), 32'h4);
        end

        // Reset while HELD.
        do_reset();
        pressed[9] = 1'b1;
        run_to(30);
        check("rh_held_pre", 32'(bus.key_held), 32'h1);
        reset   = 1'b1;
        pressed = '0;
        tick();
        check("rh_cols", 32'(bus.cols), 32'hE);
        check("rh_held", 32'(bus.key_held), 32'h0);
        check("rh_code", 32'(bus.key_code), 32'h0);
        reset = 1'b0;

        // Reset on the edge that would have produced the strobe drops it.
        do_reset();
        pressed[9] = 1'b1;
        run_to(23);
        reset = 1'b1;
        tick();
        check("rs_valid_dropped", 32'(bus.key_valid), 32'h0);
        check("rs_code", 32'(bus.key_code), 32'h0);
        reset   = 1'b0;
        pressed = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
